// File: rtl/aurora_gt_link_ctrl.sv
// Routes a contiguous group of Aurora lanes onto a QSFP GT pin bundle and supervises link
// bring-up: pma_init/reset_pb sequencing, link-up timeout with retry, status and event counters.
module aurora_gt_link_ctrl #(
    parameter int NUM_QSFP_LANES  = 4,
    parameter int NUM_LANES       = 1,
    parameter int LANE_BASE       = 0,
    parameter int PMA_INIT_CYCLES = 128,
    parameter int RESET_PB_CYCLES = 64,
    parameter int CHUP_TIMEOUT    = 1 << 20,
    parameter int MAX_RETRIES     = 8,
    parameter int CNT_W           = 16
) (
    input  logic                      init_clk,
    input  logic                      rst,
    input  logic [NUM_QSFP_LANES-1:0] GT_SERIAL_RX_0_rxp,
    input  logic [NUM_QSFP_LANES-1:0] GT_SERIAL_RX_0_rxn,
    output logic [NUM_QSFP_LANES-1:0] GT_SERIAL_TX_0_txp,
    output logic [NUM_QSFP_LANES-1:0] GT_SERIAL_TX_0_txn,
    output logic [NUM_LANES-1:0]      AuroraGT_rxp,
    output logic [NUM_LANES-1:0]      AuroraGT_rxn,
    input  logic [NUM_LANES-1:0]      AuroraGT_txp,
    input  logic [NUM_LANES-1:0]      AuroraGT_txn,
    input  logic                      enable,
    input  logic                      channel_up,
    input  logic [NUM_LANES-1:0]      lane_up,
    input  logic                      clear_cnt,
    output logic                      pma_init,
    output logic                      reset_pb,
    output logic                      link_ok,
    output logic                      link_failed,
    output logic [CNT_W-1:0]          retry_cnt,
    output logic [CNT_W-1:0]          down_cnt,
    output logic [2:0]                state
);
    localparam int MAX_PR = (PMA_INIT_CYCLES > RESET_PB_CYCLES) ? PMA_INIT_CYCLES : RESET_PB_CYCLES;
    localparam int MAX_T  = (CHUP_TIMEOUT > MAX_PR) ? CHUP_TIMEOUT : MAX_PR;
    localparam int TW     = (MAX_T > 1) ? $clog2(MAX_T) : 1;

    localparam logic [TW-1:0]    PMA_LAST    = TW'(PMA_INIT_CYCLES - 1);
    localparam logic [TW-1:0]    PB_LAST     = TW'(RESET_PB_CYCLES - 1);
    localparam logic [TW-1:0]    CHUP_LAST   = TW'(CHUP_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] RETRY_LIMIT = CNT_W'(MAX_RETRIES);
    localparam bit               LIMIT_ON    = (MAX_RETRIES != 0);

    generate
        if (LANE_BASE + NUM_LANES > NUM_QSFP_LANES) begin : g_bad_lane_map
            $error("aurora_gt_link_ctrl: LANE_BASE+NUM_LANES exceeds NUM_QSFP_LANES");
        end
        if (!(NUM_LANES == 1 || NUM_LANES == 2 || NUM_LANES == 4)) begin : g_bad_num_lanes
            $error("aurora_gt_link_ctrl: NUM_LANES must be 1, 2 or 4");
        end
        if (PMA_INIT_CYCLES < 1 || RESET_PB_CYCLES < 1 || CHUP_TIMEOUT < 1) begin : g_bad_cycles
            $error("aurora_gt_link_ctrl: cycle parameters must be at least 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PMA_RST = 3'd1,
        ST_PB_RST  = 3'd2,
        ST_WAIT_UP = 3'd3,
        ST_UP      = 3'd4,
        ST_FAIL    = 3'd5
    } state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1'b1);
    endfunction

    state_e             state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [CNT_W-1:0]   retry_cnt_q, retry_cnt_d;
    logic [CNT_W-1:0]   down_cnt_q, down_cnt_d;
    logic               pma_init_q, pma_init_d;
    logic               reset_pb_q, reset_pb_d;
    logic               link_ok_q, link_ok_d;
    logic               link_failed_q, link_failed_d;
    logic [NUM_LANES:0] meta_q, meta_d, sync_q, sync_d;
    logic               up_s;
    logic               down_inc_s;
    logic               unused_rx_pins;

    // Lane routing is pure wiring; QSFP TX lanes outside the group idle low.
    always_comb begin
        GT_SERIAL_TX_0_txp = '0;
        GT_SERIAL_TX_0_txn = '0;
        GT_SERIAL_TX_0_txp[LANE_BASE +: NUM_LANES] = AuroraGT_txp;
        GT_SERIAL_TX_0_txn[LANE_BASE +: NUM_LANES] = AuroraGT_txn;
    end

    assign AuroraGT_rxp   = GT_SERIAL_RX_0_rxp[LANE_BASE +: NUM_LANES];
    assign AuroraGT_rxn   = GT_SERIAL_RX_0_rxn[LANE_BASE +: NUM_LANES];
    assign unused_rx_pins = ^{GT_SERIAL_RX_0_rxp, GT_SERIAL_RX_0_rxn};

    // Two-flop synchronisers for channel_up (MSB) and every lane_up bit.
    always_comb begin
        meta_d = {channel_up, lane_up};
        sync_d = meta_q;
    end

    assign up_s = &sync_q;

    // Next-state, timer and counter logic; outputs are decoded from the next state.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        retry_cnt_d = retry_cnt_q;
        down_inc_s  = 1'b0;
        if (!enable) begin
            state_d     = ST_IDLE;
            timer_d     = '0;
            retry_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_PMA_RST;
                    timer_d = '0;
                end
                ST_PMA_RST: begin
                    if (timer_q == PMA_LAST) begin
                        state_d = ST_PB_RST;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TW'(1'b1);
                    end
                end
                ST_PB_RST: begin
                    if (timer_q == PB_LAST) begin
                        state_d = ST_WAIT_UP;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TW'(1'b1);
                    end
                end
                ST_WAIT_UP: begin
                    if (up_s) begin
                        state_d     = ST_UP;
                        timer_d     = '0;
                        retry_cnt_d = '0;
                    end else if (timer_q == CHUP_LAST) begin
                        timer_d     = '0;
                        retry_cnt_d = sat_inc(retry_cnt_q);
                        if (LIMIT_ON && (retry_cnt_d == RETRY_LIMIT)) begin
                            state_d = ST_FAIL;
                        end else begin
                            state_d = ST_PMA_RST;
                        end
                    end else begin
                        timer_d = timer_q + TW'(1'b1);
                    end
                end
                ST_UP: begin
                    if (!up_s) begin
                        state_d    = ST_PMA_RST;
                        timer_d    = '0;
                        down_inc_s = 1'b1;
                    end else begin
                        state_d = ST_UP;
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end
            endcase
        end
        // A coincident clear beats the channel-down increment.
        down_cnt_d    = clear_cnt ? '0 : (down_inc_s ? sat_inc(down_cnt_q) : down_cnt_q);
        pma_init_d    = (state_d == ST_IDLE) || (state_d == ST_PMA_RST) || (state_d == ST_FAIL);
        reset_pb_d    = !((state_d == ST_WAIT_UP) || (state_d == ST_UP));
        link_ok_d     = (state_d == ST_UP);
        link_failed_d = (state_d == ST_FAIL);
    end

    // State, synchroniser and output registers with synchronous reset.
    always_ff @(posedge init_clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            retry_cnt_q   <= '0;
            down_cnt_q    <= '0;
            pma_init_q    <= 1'b1;
            reset_pb_q    <= 1'b1;
            link_ok_q     <= 1'b0;
            link_failed_q <= 1'b0;
            meta_q        <= '0;
            sync_q        <= '0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            retry_cnt_q   <= retry_cnt_d;
            down_cnt_q    <= down_cnt_d;
            pma_init_q    <= pma_init_d;
            reset_pb_q    <= reset_pb_d;
            link_ok_q     <= link_ok_d;
            link_failed_q <= link_failed_d;
            meta_q        <= meta_d;
            sync_q        <= sync_d;
        end
    end

    assign pma_init    = pma_init_q;
    assign reset_pb    = reset_pb_q;
    assign link_ok     = link_ok_q;
    assign link_failed = link_failed_q;
    assign retry_cnt   = retry_cnt_q;
    assign down_cnt    = down_cnt_q;
    assign state       = state_q;

endmodule

// File: tb/tb_aurora_gt_link_ctrl.sv
// Self-checking bench for aurora_gt_link_ctrl: directed bring-up/timeout/drop scenarios plus a
// randomized run, compared every cycle against a timestamp-based behavioural model.
module tb_aurora_gt_link_ctrl;
    localparam int NQ   = 4;
    localparam int NL   = 2;
    localparam int LB   = 1;
    localparam int P    = 8;
    localparam int R    = 4;
    localparam int T    = 20;
    localparam int MR   = 2;
    localparam int CW   = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NQ-1:0] qrxp = '0, qrxn = '0, qtxp, qtxn;
    logic [NL-1:0] arxp, arxn, atxp = '0, atxn = '0;
    logic          enable = 1'b0, channel_up = 1'b0, clear_cnt = 1'b0;
    logic [NL-1:0] lane_up = '0;
    logic          pma_init, reset_pb, link_ok, link_failed;
    logic [CW-1:0] retry_cnt, down_cnt;
    logic [2:0]    state;

    aurora_gt_link_ctrl #(
        .NUM_QSFP_LANES(NQ), .NUM_LANES(NL), .LANE_BASE(LB), .PMA_INIT_CYCLES(P),
        .RESET_PB_CYCLES(R), .CHUP_TIMEOUT(T), .MAX_RETRIES(MR), .CNT_W(CW)
    ) dut (
        .init_clk(clk), .rst(rst),
        .GT_SERIAL_RX_0_rxp(qrxp), .GT_SERIAL_RX_0_rxn(qrxn),
        .GT_SERIAL_TX_0_txp(qtxp), .GT_SERIAL_TX_0_txn(qtxn),
        .AuroraGT_rxp(arxp), .AuroraGT_rxn(arxn),
        .AuroraGT_txp(atxp), .AuroraGT_txn(atxn),
        .enable(enable), .channel_up(channel_up), .lane_up(lane_up), .clear_cnt(clear_cnt),
        .pma_init(pma_init), .reset_pb(reset_pb), .link_ok(link_ok), .link_failed(link_failed),
        .retry_cnt(retry_cnt), .down_cnt(down_cnt), .state(state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // Model: phase plus the edge number it was entered on; link-up seen two edges late.
    int m_state = 0, m_retry = 0, m_down = 0, m_tin = 0, m_n = 0;
    bit m_h1 = 1'b0, m_h2 = 1'b0;
    bit chk_en = 1'b0;

    always @(posedge clk) begin : model
        bit up_now, inc;
        m_n++;
        if (rst) begin
            m_state = 0; m_retry = 0; m_down = 0; m_h1 = 1'b0; m_h2 = 1'b0;
        end else begin
            up_now = m_h2;
            m_h2   = m_h1;
            m_h1   = channel_up && (lane_up == 2'b11);
            inc    = 1'b0;
            if (!enable) begin
                m_state = 0; m_retry = 0;
            end else begin
                case (m_state)
                    0: begin m_state = 1; m_tin = m_n; end
                    1: if (m_n - m_tin == P) begin m_state = 2; m_tin = m_n; end
                    2: if (m_n - m_tin == R) begin m_state = 3; m_tin = m_n; end
                    3: if (up_now) begin
                           m_state = 4; m_retry = 0;
                       end else if (m_n - m_tin == T) begin
                           m_retry = (m_retry < CMAX) ? m_retry + 1 : CMAX;
                           m_state = (MR != 0 && m_retry == MR) ? 5 : 1;
                           m_tin   = m_n;
                       end
                    4: if (!up_now) begin inc = 1'b1; m_state = 1; m_tin = m_n; end
                    default: ;
                endcase
            end
            if (clear_cnt) m_down = 0;
            else if (inc) m_down = (m_down < CMAX) ? m_down + 1 : CMAX;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_state", int'(state), m_state);
            chk("model_flags", int'({pma_init, reset_pb, link_ok, link_failed}),
                ((m_state == 0 || m_state == 1 || m_state == 5) ? 8 : 0) +
                ((m_state == 3 || m_state == 4) ? 0 : 4) +
                ((m_state == 4) ? 2 : 0) + ((m_state == 5) ? 1 : 0));
            chk("model_retry", int'(retry_cnt), m_retry);
            chk("model_down", int'(down_cnt), m_down);
        end
    end

    task automatic route_check();
        logic [NQ-1:0] etp, etn;
        logic [NL-1:0] erp, ern;
        etp = '0; etn = '0;
        for (int i = 0; i < NL; i++) begin
            etp[LB+i] = atxp[i]; etn[LB+i] = atxn[i];
            erp[i] = qrxp[LB+i]; ern[i] = qrxn[LB+i];
        end
        chk("route_txp", int'(qtxp), int'(etp));
        chk("route_txn", int'(qtxn), int'(etn));
        chk("route_rxp", int'(arxp), int'(erp));
        chk("route_rxn", int'(arxn), int'(ern));
    endtask

    task automatic drop_cycle(input int exp_down, input bit clr);
        channel_up = 1'b0;
        tick(1);
        channel_up = 1'b1;
        if (clr) begin
            tick(1); clear_cnt = 1'b1; tick(1); clear_cnt = 1'b0;
        end else begin
            tick(2);
        end
        chk("drop_state_pma_rst", int'(state), 1);
        chk("drop_pma_init", int'(pma_init), 1);
        chk("drop_down_cnt", int'(down_cnt), exp_down);
        tick(13);
        chk("drop_relink", int'(link_ok), 1);
    endtask

    initial begin
        tick(1);
        chk_en = 1'b1;
        tick(1);
        chk("rst_state", int'(state), 0);
        chk("rst_resets", int'({pma_init, reset_pb}), 3);
        chk("rst_status", int'({link_ok, link_failed}), 0);
        chk("rst_counters", int'({retry_cnt, down_cnt}), 0);

        qrxp = 4'b0010; #1 chk("route_rx1", int'(arxp), 1);
        qrxp = 4'b0100; #1 chk("route_rx2", int'(arxp), 2);
        atxn = 2'b01;   #1 chk("route_tx0", int'(qtxn), 2);
        atxn = 2'b10;   #1 chk("route_tx1", int'(qtxn), 4);
        atxp = 2'b11; qrxn = 4'b1001; #1 chk("route_edges", int'({qtxp[3], qtxp[0], arxn}), 0);
        for (int i = 0; i < 6; i++) begin
            qrxp = 4'($urandom); qrxn = 4'($urandom); atxp = 2'($urandom); atxn = 2'($urandom);
            #1 route_check();
        end

        rst = 1'b0;
        tick(1);
        // Bring-up: enable after edge 0, link-up inputs after edge 20.
        enable = 1'b1;
        tick(1);  chk("bu_state_e1", int'(state), 1);
        tick(7);  chk("bu_pma_e8", int'(pma_init), 1);
        tick(1);  chk("bu_pma_e9", int'(pma_init), 0);
        chk("bu_pb_e9", int'(reset_pb), 1);
        tick(3);  chk("bu_pb_e12", int'(reset_pb), 1);
        tick(1);  chk("bu_pb_e13", int'(reset_pb), 0);
        tick(7);  channel_up = 1'b1; lane_up = 2'b11;
        tick(2);  chk("bu_ok_e22", int'(link_ok), 0);
        tick(1);  chk("bu_ok_e23", int'(link_ok), 1);
        chk("bu_retry", int'(retry_cnt), 0);

        for (int i = 1; i <= 3; i++) drop_cycle(i, 1'b0);
        drop_cycle(0, 1'b1);
        for (int i = 1; i <= 8; i++) drop_cycle((i < CMAX) ? i : CMAX, 1'b0);

        // Timeout: link-up held low for two attempts.
        enable = 1'b0; channel_up = 1'b0; lane_up = 2'b00;
        tick(3);
        chk("to_idle", int'(state), 0);
        enable = 1'b1;
        tick(32); chk("to_wait_e32", int'(state), 3);
        chk("to_retry_e32", int'(retry_cnt), 0);
        tick(1);  chk("to_state_e33", int'(state), 1);
        chk("to_retry_e33", int'(retry_cnt), 1);
        tick(32); chk("to_fail_state", int'(state), 5);
        chk("to_fail_flags", int'({link_failed, pma_init, reset_pb, link_ok}), 14);
        chk("to_fail_retry", int'(retry_cnt), 2);
        tick(5);  chk("to_fail_hold", int'(state), 5);
        enable = 1'b0;
        tick(1);  chk("to_exit_idle", int'(state), 0);
        chk("to_exit_retry", int'(retry_cnt), 0);

        // Partial lanes never reach UP; then reset during the second wait.
        channel_up = 1'b1; lane_up = 2'b01;
        tick(2);
        enable = 1'b1;
        tick(32); chk("pl_wait_e32", int'(state), 3);
        tick(1);  chk("pl_retry_state", int'(state), 1);
        chk("pl_retry", int'(retry_cnt), 1);
        tick(17); chk("pl_wait_e50", int'(state), 3);
        chk("pl_down_before_rst", int'(down_cnt), CMAX);
        rst = 1'b1;
        tick(1);
        chk("mid_rst_state", int'(state), 0);
        chk("mid_rst_resets", int'({pma_init, reset_pb}), 3);
        chk("mid_rst_counters", int'({retry_cnt, down_cnt}), 0);
        rst = 1'b0;

        for (int c = 0; c < 3000; c++) begin
            enable = ($urandom_range(0, 99) >= 3);
            if ($urandom_range(0, 99) < 4) begin
                channel_up = ($urandom_range(0, 99) < 75);
                lane_up = ($urandom_range(0, 99) < 75) ? 2'b11 : 2'($urandom);
            end
            clear_cnt = ($urandom_range(0, 499) == 0);
            rst = ($urandom_range(0, 999) == 0);
            qrxp = 4'($urandom); qrxn = 4'($urandom); atxp = 2'($urandom); atxn = 2'($urandom);
            #1 route_check();
            tick(1);
        end
        rst = 1'b0;
        clear_cnt = 1'b0;
        tick(1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/aurora_gt_link_ctrl.md
# aurora_gt_link_ctrl

Parametrised successor to the single-lane Aurora GT pin wrapper. It statically routes a contiguous group of `NUM_LANES` Aurora serial lanes onto a `NUM_QSFP_LANES`-wide QSFP GT pin bundle. It also sequences the Aurora core's `pma_init` and `reset_pb`, supervises `channel_up`/`lane_up`, retries on timeout or channel-down, and exposes link status and event counters. It sits between the QSFP GT pins and the Aurora core in the block design and runs on the core's free-running init clock.

## Interface
Parameters:
- `NUM_QSFP_LANES`, 4: width of the QSFP GT pin bundle.
- `NUM_LANES`, 1: Aurora lanes routed; 1, 2 or 4.
- `LANE_BASE`, 0: first QSFP lane used. Elaboration error if `LANE_BASE+NUM_LANES > NUM_QSFP_LANES`.
- `PMA_INIT_CYCLES`, 128: cycles `pma_init` is held per attempt; minimum 1.
- `RESET_PB_CYCLES`, 64: cycles `reset_pb` stays high after `pma_init` release; minimum 1.
- `CHUP_TIMEOUT`, 2^20: cycles allowed for link-up per attempt.
- `MAX_RETRIES`, 8: consecutive failed attempts before FAIL; 0 = retry forever.
- `CNT_W`, 16: width of the event counters.

Ports:
- Clocking and reset: one clock, `init_clk`; reset is synchronous and active-high, `rst`.
- `init_clk`  in  1  free-running init clock.
- `rst`  in  1  synchronous active-high reset.
- `GT_SERIAL_RX_0_rxp` / `GT_SERIAL_RX_0_rxn`  in  NUM_QSFP_LANES  QSFP RX pins.
- `GT_SERIAL_TX_0_txp` / `GT_SERIAL_TX_0_txn`  out  NUM_QSFP_LANES  QSFP TX pins.
- `AuroraGT_rxp` / `AuroraGT_rxn`  out  NUM_LANES  RX pins to the Aurora core.
- `AuroraGT_txp` / `AuroraGT_txn`  in  NUM_LANES  TX pins from the Aurora core.
- `enable`  in  1  link requested.
- `channel_up`  in  1  from the Aurora core; asynchronous to `init_clk`.
- `lane_up`  in  NUM_LANES  from the Aurora core; asynchronous to `init_clk`.
- `clear_cnt`  in  1  clears `down_cnt`.
- `pma_init`  out  1  to the Aurora core.
- `reset_pb`  out  1  to the Aurora core.
- `link_ok`  out  1  state is UP.
- `link_failed`  out  1  state is FAIL.
- `retry_cnt`  out  CNT_W  consecutive failed attempts.
- `down_cnt`  out  CNT_W  channel-down events seen in UP.
- `state`  out  3  encoding: IDLE=0, PMA_RST=1, PB_RST=2, WAIT_UP=3, UP=4, FAIL=5.

## Operation
- Pin routing is purely combinational:
  - Lane i (0..NUM_LANES-1) maps to QSFP lane `LANE_BASE+i`, for rx and tx, p and n.
  - Unused QSFP TX pins are driven 0. Unused RX pins are left unconnected.
- Synchronisation: `channel_up` and each `lane_up` bit pass through two flops. Define `up_s` = synced `channel_up` AND all synced `lane_up` bits.
- FSM:
  - IDLE: `pma_init`=1, `reset_pb`=1. If `enable`=1, go to PMA_RST.
  - PMA_RST: `pma_init`=1, `reset_pb`=1 for exactly PMA_INIT_CYCLES cycles, then go to PB_RST.
  - PB_RST: `pma_init`=0, `reset_pb`=1 for exactly RESET_PB_CYCLES cycles, then go to WAIT_UP.
  - WAIT_UP: both resets 0; the timer counts.
    - If `up_s`=1: go to UP and clear `retry_cnt`.
    - If the timer reaches CHUP_TIMEOUT with `up_s`=0: `retry_cnt`+1. Go to FAIL if `MAX_RETRIES`≠0 and the new value equals MAX_RETRIES, otherwise go to PMA_RST.
    - If `up_s` and timeout coincide, `up_s` wins.
  - UP: `link_ok`=1. If `up_s` falls: `down_cnt`+1, then go to PMA_RST.
  - FAIL: both resets 1, `link_failed`=1. Exit only via `enable`=0, which goes to IDLE.
- Override: `enable`=0 in any state goes to IDLE on the next edge. The timer and `retry_cnt` are cleared.
- Counters saturate at 2^CNT_W-1.
- `clear_cnt` zeroes `down_cnt`. When `clear_cnt` coincides with an increment, clear wins and the result is 0.

## Timing
- Reset values: state IDLE, `pma_init`=1, `reset_pb`=1, `link_ok`=0, `link_failed`=0, both counters 0, synchronisers 0.
- All control outputs are registered and decoded from the state register. Routing paths have no latency.
- `enable` rising in IDLE at edge k:
  - State is PMA_RST from edge k+1.
  - `pma_init` falls at edge k+1+PMA_INIT_CYCLES.
  - `reset_pb` falls RESET_PB_CYCLES later.
- `channel_up` input to `link_ok`: 3 edges (2 sync + 1 state).
- `channel_up` drop in UP to `pma_init`=1: 3 edges.
- Each state's timer is cleared on state entry.
- Reset mid-operation: `rst` overrides everything and restores the reset values on the next edge.

## Test plan
Test parameters: PMA_INIT_CYCLES=8, RESET_PB_CYCLES=4, CHUP_TIMEOUT=20, MAX_RETRIES=2, NUM_LANES=2, LANE_BASE=1.
- Routing: toggle QSFP RX[1], RX[2] and Aurora TX[0], TX[1].
  - Required: mirrored same-cycle on the mapped pins.
  - Required: QSFP TX[0] and TX[3] stay 0.
- Bring-up: `enable`=1 at edge 0, `channel_up` and `lane_up`=2'b11 at edge 20.
  - Required: `pma_init` high for edges 1–8, falls at edge 9.
  - Required: `reset_pb` falls at edge 13.
  - Required: `link_ok`=1 at edge 23, `retry_cnt`=0.
- Timeout: hold `up_s` low.
  - Required: `retry_cnt`=1 after the first timeout, then the FSM re-enters PMA_RST.
  - Required: after the second timeout, state=FAIL, `link_failed`=1, both resets 1.
  - Required: `enable`=0 then returns state to IDLE.
- Partial lanes: `channel_up`=1, `lane_up`=2'b01. Required: no UP; timeout path taken.
- Channel-down: in UP, drop `channel_up` for 1 cycle, three times.
  - Required: `down_cnt`=3, with the re-init sequence run each time.
  - Required: `clear_cnt` together with a fourth drop leaves `down_cnt`=0.
- `rst` asserted in WAIT_UP. Required: the next edge shows state=0, both resets 1, counters 0.
